// File: rtl/fmc_bus_sync.sv
// STM32 FMC NE1 multiplexed-bus front-end: strobe sync, address latch, req strobes.
// Optional bus-cycle watchdog with sticky error when FMC_TIMEOUT_EN is defined.
module fmc_bus_sync #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] DA_IN,
  input  logic [6:0]  A,
  input  logic        NL,
  input  logic        NOE,
  input  logic        NWE,
  input  logic        NE1,
  input  logic        NBL0,
  input  logic        NBL1,
  output logic [15:0] DA_OUT,
  output logic [15:0] DA_OE,
  output logic [23:0] addr,
  output logic        wr_stb,
  output logic [15:0] wr_data,
  output logic [1:0]  wr_be,
  output logic        rd_stb,
  input  logic [15:0] rd_data,
  output logic        busy
`ifdef FMC_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEL  = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RD   = 2'd3;
  localparam logic [SYNC_STAGES-1:0] FILL_ONE = 1;

  logic [5:0]  st_q [SYNC_STAGES];
  logic [22:0] dt_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        st_q[i] <= 6'h3F;
        dt_q[i] <= '0;
      end
      fill_q <= '0;
    end else begin
      st_q[0] <= {NL, NOE, NWE, NE1, NBL0, NBL1};
      dt_q[0] <= {A, DA_IN};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        st_q[i] <= st_q[i-1];
        dt_q[i] <= dt_q[i-1];
      end
      fill_q <= (fill_q << 1) | FILL_ONE;
    end
  end

  logic nl_s, noe_s, nwe_s, ne1_s, nbl0_s, nbl1_s, sync_ok;
  logic [6:0]  a_s;
  logic [15:0] da_s;

  assign {nl_s, noe_s, nwe_s, ne1_s, nbl0_s, nbl1_s} = st_q[SYNC_STAGES-1];
  assign {a_s, da_s} = dt_q[SYNC_STAGES-1];
  assign sync_ok = fill_q[SYNC_STAGES-1];

  logic [1:0]  state_q, state_d;
  logic        arm_q, arm_d, noe_ok_q, noe_ok_d, oe_q, oe_d;
  logic        wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
  logic [15:0] wr_data_q, wr_data_d, da_out_q, da_out_d;
  logic [1:0]  wr_be_q, wr_be_d;
  logic [23:0] addr_q, addr_d;
  logic        to_hit;

`ifdef FMC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q;

  assign to_hit = !ne1_s && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign cnt_d  = ne1_s ? '0 : (to_hit ? cnt_q : cnt_q + TW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (to_hit) err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    noe_ok_d  = noe_ok_q;
    oe_d      = oe_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    da_out_d  = da_out_q;
    addr_d    = nl_s ? addr_q : {a_s, da_s, ~nbl1_s};
    // Only start a cycle once NE1 has been seen idle after reset/timeout
    if (sync_ok && ne1_s) arm_d = 1'b1;
    if (noe_s) noe_ok_d = 1'b1;
    unique case (state_q)
      IDLE: if (arm_q && !ne1_s) state_d = SEL;
      SEL: begin
        if (ne1_s) begin
          state_d = IDLE;
        end else if (!nwe_s) begin
          state_d   = WR;
          wr_data_d = da_s;
          wr_be_d   = {~nbl1_s, ~nbl0_s};
          noe_ok_d  = noe_s;
        end else if (!noe_s && noe_ok_q) begin
          state_d  = RD;
          rd_stb_d = 1'b1;
          noe_ok_d = 1'b0;
        end
      end
      WR: begin
        if (nwe_s) begin
          wr_stb_d = 1'b1;
          state_d  = ne1_s ? IDLE : SEL;
        end else if (ne1_s) begin
          state_d = IDLE;
        end else begin
          wr_data_d = da_s;
          wr_be_d   = {~nbl1_s, ~nbl0_s};
        end
      end
      RD: begin
        if (ne1_s || noe_s) begin
          oe_d    = 1'b0;
          state_d = ne1_s ? IDLE : SEL;
        end else if (rd_stb_q) begin
          da_out_d = rd_data;
          oe_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (to_hit) begin
      state_d  = IDLE;
      arm_d    = 1'b0;
      oe_d     = 1'b0;
      wr_stb_d = 1'b0;
      rd_stb_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      arm_q     <= 1'b0;
      noe_ok_q  <= 1'b0;
      oe_q      <= 1'b0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      da_out_q  <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      noe_ok_q  <= noe_ok_d;
      oe_q      <= oe_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      da_out_q  <= da_out_d;
      addr_q    <= addr_d;
    end
  end

  // Output enable drops combinationally as soon as NOE_s or NE1_s releases
  assign DA_OE   = (oe_q && !noe_s && !ne1_s) ? 16'hFFFF : 16'h0000;
  assign DA_OUT  = da_out_q;
  assign addr    = addr_q;
  assign wr_stb  = wr_stb_q;
  assign wr_data = wr_data_q;
  assign wr_be   = wr_be_q;
  assign rd_stb  = rd_stb_q;
  assign busy    = !ne1_s;

endmodule

// File: tb/tb_fmc_bus_sync.sv
// Directed bench for fmc_bus_sync with a write scoreboard.
// Define FMC_TIMEOUT_EN to also exercise the watchdog.
module tb_fmc_bus_sync;

  localparam int SS = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] DA_IN;
  logic [6:0]  A;
  logic        NL, NOE, NWE, NE1, NBL0, NBL1;
  logic [15:0] DA_OUT, DA_OE, wr_data, rd_data;
  logic [23:0] addr;
  logic        wr_stb, rd_stb, busy;
  logic [1:0]  wr_be;
`ifdef FMC_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clock = ~clock;

  fmc_bus_sync #(
    .SYNC_STAGES(SS)
`ifdef FMC_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clock(clock), .reset(reset), .DA_IN(DA_IN), .A(A),
    .NL(NL), .NOE(NOE), .NWE(NWE), .NE1(NE1),
    .NBL0(NBL0), .NBL1(NBL1), .DA_OUT(DA_OUT), .DA_OE(DA_OE),
    .addr(addr), .wr_stb(wr_stb), .wr_data(wr_data), .wr_be(wr_be),
    .rd_stb(rd_stb), .rd_data(rd_data), .busy(busy)
`ifdef FMC_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  be;
  } wr_t;

  wr_t wq[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  int  rd_cnt = 0;
  int  lat;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Scoreboard side: pop an expected write on every wr_stb
  always @(negedge clock) begin
    if (!reset) begin
      if (wr_stb) begin
        wr_cnt++;
        chk("wr_expected", 32'(wq.size() != 0), 32'd1);
        chk("strobe_excl", 32'(rd_stb), 32'd0);
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_data", 32'(wr_data), 32'(e.d));
          chk("wr_be", 32'(wr_be), 32'(e.be));
        end
      end
      if (rd_stb) rd_cnt++;
    end
  end

  task automatic wait_wr(output int n);
    n = 0;
    while (!wr_stb && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("wr_stb_seen", 32'(wr_stb), 32'd1);
  endtask

  task automatic wait_rd(output int n);
    n = 0;
    while (!rd_stb && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("rd_stb_seen", 32'(rd_stb), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    {NL, NOE, NWE, NE1, NBL0, NBL1} = 6'h3F;
    DA_IN = '0; A = '0; rd_data = '0;
    tick(3);
    chk("rst_da_oe", 32'(DA_OE), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(20);
    chk("idle_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("idle_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("idle_outs", {DA_OUT, 7'd0, wr_stb, rd_stb, wr_be, busy, 3'd0},
        32'd0);
    chk("idle_addr", 32'(addr), 32'd0);

    // Address phase then full-word write
    NE1 = 0; NL = 0; A = 7'h01; DA_IN = 16'h0006; NBL1 = 0; NBL0 = 0;
    tick(3);
    chk("busy_low", 32'(busy), 32'd1);
    NL = 1;
    DA_IN = 16'hBEEF; NWE = 0;
    wq.push_back('{d: 16'hBEEF, be: 2'b11});
    tick(3);
    NWE = 1;
    wait_wr(lat);
    chk("wr_latency", 32'(lat), 32'(SS + 1));
    chk("addr_latch", 32'(addr), 32'({7'h01, 16'h0006, 1'b1}));

    // Byte write in the same NE1 window
    tick(2);
    DA_IN = 16'h00A5; NBL0 = 0; NBL1 = 1; NWE = 0;
    wq.push_back('{d: 16'h00A5, be: 2'b01});
    tick(3);
    NWE = 1;
    wait_wr(lat);
    chk("byte_latency", 32'(lat), 32'(SS + 1));
    NE1 = 1; NBL1 = 0;
    tick(4);
    chk("wr_count2", 32'(wr_cnt), 32'd2);
    chk("busy_rel", 32'(busy), 32'd0);

    // Read cycle
    NE1 = 0;
    tick(3);
    rd_data = 16'h1234; NOE = 0;
    wait_rd(lat);
    chk("oe_at_rdstb", 32'(DA_OE), 32'd0);
    tick(1);
    chk("rd_da_out", 32'(DA_OUT), 32'h1234);
    chk("rd_da_oe", 32'(DA_OE), 32'hFFFF);
    tick(2);
    NOE = 1;
    tick(1);
    chk("oe_hold", 32'(DA_OE), 32'hFFFF);
    tick(1);
    chk("oe_release", 32'(DA_OE), 32'd0);
    chk("rd_count1", 32'(rd_cnt), 32'd1);
    NE1 = 1;
    tick(4);

    // NE1 rises while NWE still low: aborted write
    NE1 = 0;
    tick(3);
    DA_IN = 16'h1111; NWE = 0;
    tick(3);
    NE1 = 1;
    tick(3);
    NWE = 1;
    tick(5);
    chk("abort_no_wr", 32'(wr_cnt), 32'd2);
    chk("abort_idle", 32'(dut.state_q), 32'd0);

    // NWE and NOE low together: write wins
    NE1 = 0;
    tick(3);
    DA_IN = 16'h2222; NBL0 = 0; NBL1 = 0; NWE = 0; NOE = 0;
    wq.push_back('{d: 16'h2222, be: 2'b11});
    tick(4);
    chk("both_oe", 32'(DA_OE), 32'd0);
    NWE = 1; NOE = 1;
    tick(5);
    chk("both_wr", 32'(wr_cnt), 32'd3);
    chk("both_no_rd", 32'(rd_cnt), 32'd1);
    NE1 = 1;
    tick(4);

    // Reset in the middle of a read
    NE1 = 0;
    tick(3);
    NOE = 0;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_oe", 32'(DA_OE), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(10);
    chk("mid_rst_rd", 32'(rd_cnt), 32'd2);
    chk("mid_rst_idle", 32'(dut.state_q), 32'd0);
    NE1 = 1; NOE = 1;
    tick(4);

    // Bus works again once NE1 has been seen high
    NE1 = 0;
    tick(3);
    DA_IN = 16'h5A5A; NWE = 0;
    wq.push_back('{d: 16'h5A5A, be: 2'b11});
    tick(3);
    NWE = 1;
    wait_wr(lat);
    NE1 = 1;
    tick(4);
    chk("wq_empty", 32'(wq.size()), 32'd0);

`ifdef FMC_TIMEOUT_EN
    chk("to_err_init", 32'(timeout_err), 32'd0);
    NE1 = 0;
    tick(3);
    NOE = 0;
    tick(20);
    chk("to_oe", 32'(DA_OE), 32'd0);
    chk("to_err", 32'(timeout_err), 32'd1);
    NE1 = 1; NOE = 1;
    tick(4);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("to_err_clr", 32'(timeout_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
